// File: rtl/radix2_inv_butterfly_pkg.sv
// Shared constants and types for the radix-2 inverse butterfly datapath.
package radix2_inv_butterfly_pkg;

  localparam int unsigned DEF_BIT_WIDTH    = 16;
  localparam int unsigned DEF_TW_WIDTH     = 8;

  // Twiddle words carry unity as 2^(width-2), leaving headroom for the sign.
  function automatic int unsigned tw_shift(input int unsigned tw_width);
    return tw_width - 2;
  endfunction

  localparam int unsigned TW_SHIFT = tw_shift(DEF_TW_WIDTH);
  localparam int unsigned TW_ONE   = 1 << TW_SHIFT;

  typedef struct packed {
    logic signed [DEF_BIT_WIDTH-1:0] re;
    logic signed [DEF_BIT_WIDTH-1:0] im;
  } cmplx_t;

endpackage

// File: rtl/radix2_inv_butterfly_cmplx_conj_mult.sv
// Registered complex multiply by conj(W), scaled back by the twiddle unity; wraps on overflow.
module cmplx_conj_mult
  import radix2_inv_butterfly_pkg::*;
#(
  parameter int unsigned bit_width           = DEF_BIT_WIDTH,
  parameter int unsigned bit_width_tw_factor = DEF_TW_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  in_valid,
  input  logic signed [bit_width-1:0]           d_re,
  input  logic signed [bit_width-1:0]           d_im,
  input  logic signed [bit_width_tw_factor-1:0] cos_data,
  input  logic signed [bit_width_tw_factor-1:0] sin_data,
  output logic                                  out_valid,
  output logic signed [bit_width-1:0]           re,
  output logic signed [bit_width-1:0]           im
);

  localparam int unsigned P     = bit_width + bit_width_tw_factor + 1;
  localparam int unsigned SHIFT = tw_shift(bit_width_tw_factor);

  logic signed [P-1:0] dre_x, dim_x, cos_x, sin_x;
  logic signed [P-1:0] acc_re, acc_im;

  always_comb begin
    dre_x  = P'(d_re);
    dim_x  = P'(d_im);
    cos_x  = P'(cos_data);
    sin_x  = P'(sin_data);
    acc_re = dre_x * cos_x + dim_x * sin_x;
    acc_im = dim_x * cos_x - dre_x * sin_x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      re        <= '0;
      im        <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      re        <= bit_width'(acc_re >>> SHIFT);
      im        <= bit_width'(acc_im >>> SHIFT);
    end
  end

endmodule

// File: rtl/radix2_inv_butterfly.sv
// Pipelined radix-2 inverse butterfly: x1 = (X1+X2)/2, x2 = ((X1-X2)/2)*conj(W), 3-cycle latency.
module radix2_inv_butterfly
  import radix2_inv_butterfly_pkg::*;
#(
  parameter int unsigned bit_width           = DEF_BIT_WIDTH,
  parameter int unsigned bit_width_tw_factor = DEF_TW_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [bit_width_tw_factor-1:0] cos_data,
  input  logic signed [bit_width_tw_factor-1:0] sin_data,
  input  logic signed [bit_width-1:0]           Re_i1,
  input  logic signed [bit_width-1:0]           Im_i1,
  input  logic signed [bit_width-1:0]           Re_i2,
  input  logic signed [bit_width-1:0]           Im_i2,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [bit_width-1:0]           Re_o1,
  output logic signed [bit_width-1:0]           Im_o1,
  output logic signed [bit_width-1:0]           Re_o2,
  output logic signed [bit_width-1:0]           Im_o2
);

  logic stall;
  logic signed [bit_width:0] sum_re, sum_im, dif_re, dif_im;

  logic                                  v1;
  logic signed [bit_width-1:0]           s1_re, s1_im, d1_re, d1_im;
  logic signed [bit_width_tw_factor-1:0] cos1, sin1;

  logic                                  v2;
  logic signed [bit_width-1:0]           s2_re, s2_im, m_re, m_im;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Sign-extend by one bit so the sum/difference never overflows before halving.
  always_comb begin
    sum_re = {Re_i1[bit_width-1], Re_i1} + {Re_i2[bit_width-1], Re_i2};
    sum_im = {Im_i1[bit_width-1], Im_i1} + {Im_i2[bit_width-1], Im_i2};
    dif_re = {Re_i1[bit_width-1], Re_i1} - {Re_i2[bit_width-1], Re_i2};
    dif_im = {Im_i1[bit_width-1], Im_i1} - {Im_i2[bit_width-1], Im_i2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      s1_re <= '0;
      s1_im <= '0;
      d1_re <= '0;
      d1_im <= '0;
      cos1  <= '0;
      sin1  <= '0;
    end else if (!stall) begin
      v1    <= in_valid;
      s1_re <= bit_width'(sum_re >>> 1);
      s1_im <= bit_width'(sum_im >>> 1);
      d1_re <= bit_width'(dif_re >>> 1);
      d1_im <= bit_width'(dif_im >>> 1);
      cos1  <= cos_data;
      sin1  <= sin_data;
    end
  end

  cmplx_conj_mult #(
    .bit_width          (bit_width),
    .bit_width_tw_factor(bit_width_tw_factor)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .en       (!stall),
    .in_valid (v1),
    .d_re     (d1_re),
    .d_im     (d1_im),
    .cos_data (cos1),
    .sin_data (sin1),
    .out_valid(v2),
    .re       (m_re),
    .im       (m_im)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_re     <= '0;
      s2_im     <= '0;
      out_valid <= 1'b0;
      Re_o1     <= '0;
      Im_o1     <= '0;
      Re_o2     <= '0;
      Im_o2     <= '0;
    end else if (!stall) begin
      s2_re     <= s1_re;
      s2_im     <= s1_im;
      out_valid <= v2;
      Re_o1     <= s2_re;
      Im_o1     <= s2_im;
      Re_o2     <= m_re;
      Im_o2     <= m_im;
    end
  end

endmodule

// File: tb/tb_radix2_inv_butterfly.sv
// Scoreboard bench for radix2_inv_butterfly using directed vectors with hand-computed results.
module tb_radix2_inv_butterfly;
  import radix2_inv_butterfly_pkg::*;

  typedef struct {
    cmplx_t x1;
    cmplx_t x2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [7:0]  cos_data = '0, sin_data = '0;
  logic signed [15:0] Re_i1 = '0, Im_i1 = '0, Re_i2 = '0, Im_i2 = '0;
  logic signed [15:0] Re_o1, Im_o1, Re_o2, Im_o2;

  int   checks = 0;
  int   errors = 0;
  int   handshakes = 0;
  exp_t sb[$];

  radix2_inv_butterfly #(
    .bit_width          (16),
    .bit_width_tw_factor(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cos_data (cos_data),
    .sin_data (sin_data),
    .Re_i1    (Re_i1),
    .Im_i1    (Im_i1),
    .Re_i2    (Re_i2),
    .Im_i2    (Im_i2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Re_o1    (Re_o1),
    .Im_o1    (Im_o1),
    .Re_o2    (Re_o2),
    .Im_o2    (Im_o2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every output handshake pops and compares the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      handshakes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got x1=(%0d,%0d) x2=(%0d,%0d), expected none",
                 Re_o1, Im_o1, Re_o2, Im_o2);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Re_o1 != e.x1.re || Im_o1 != e.x1.im || Re_o2 != e.x2.re || Im_o2 != e.x2.im) begin
          errors++;
          $display("FAIL beat: got x1=(%0d,%0d) x2=(%0d,%0d), expected x1=(%0d,%0d) x2=(%0d,%0d)",
                   Re_o1, Im_o1, Re_o2, Im_o2, e.x1.re, e.x1.im, e.x2.re, e.x2.im);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int x1r, input int x1i, input int x2r, input int x2i,
                      input int c, input int s,
                      input int e1r, input int e1i, input int e2r, input int e2i,
                      input bit track);
    int   n;
    exp_t e;
    Re_i1 = 16'(x1r); Im_i1 = 16'(x1i);
    Re_i2 = 16'(x2r); Im_i2 = 16'(x2i);
    cos_data = 8'(c); sin_data = 8'(s);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      e.x1.re = 16'(e1r); e.x1.im = 16'(e1i);
      e.x2.re = 16'(e2r); e.x2.im = 16'(e2i);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, sb.size(), 0);
  endtask

  initial begin
    logic signed [15:0] h_r1, h_i1, h_r2, h_i2;
    int base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs_zero", {Re_o1, Im_o1, Re_o2, Im_o2}, 0);
    @(posedge clk); #1;

    // Unity twiddle; also pins latency at 3 and a single-cycle out_valid pulse.
    send(300, 0, 100, 0, TW_ONE, 0, 200, 0, 100, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("latency_out_valid_c%0d", i), out_valid, (i == 2) ? 1 : 0);
    end
    @(posedge clk); #1;

    send(10, 0, -10, 0, 0, -64, 0, 0, 0, 10, 1'b1);          // W = -j
    send(3, -3, 0, 0, TW_ONE, 0, 1, -2, 1, -2, 1'b1);          // floor rounding
    send(32767, -32768, 32767, -32768, TW_ONE, 0, 32767, -32768, 0, 0, 1'b1);
    send(32767, 0, -32768, 0, 127, 127, -1, 0, -514, 513, 1'b1); // product wraps
    drain("drain_directed");

    // Back-to-back stream with a 4-cycle output stall in the middle.
    base = handshakes;
    fork
      begin
        send(40, 20, 20, 10, TW_ONE, 0, 30, 15, 10, 5, 1'b1);
        send(40, 20, 20, 10, 0, 64, 30, 15, 5, -10, 1'b1);
        send(-7, 9, 2, -4, TW_ONE, 0, -3, 2, -5, 6, 1'b1);
        send(100, -50, -100, 50, -64, 0, 0, 0, -100, 50, 1'b1);
        send(1000, 0, 0, 1000, 45, 45, 500, 500, 0, -704, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        h_r1 = Re_o1; h_i1 = Im_o1; h_r2 = Re_o2; h_i2 = Im_o2;
        chk("stall_entry_out_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk($sformatf("stall_in_ready_c%0d", i), in_ready, 0);
          chk($sformatf("stall_out_valid_c%0d", i), out_valid, 1);
          chk($sformatf("stall_hold_c%0d", i), {Re_o1, Im_o1, Re_o2, Im_o2},
              {h_r1, h_i1, h_r2, h_i2});
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stream");
    chk("stream_beat_count", handshakes - base, 5);

    // Reset with three untracked beats in flight: none may ever come out.
    base = handshakes;
    send(1, 1, 1, 1, TW_ONE, 0, 0, 0, 0, 0, 1'b0);
    send(2, 2, 2, 2, TW_ONE, 0, 0, 0, 0, 0, 1'b0);
    send(3, 3, 3, 3, TW_ONE, 0, 0, 0, 0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_outputs_zero", {Re_o1, Im_o1, Re_o2, Im_o2}, 0);
    chk("midreset_in_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    chk("midreset_no_stale", handshakes - base, 0);

    // Pipe still works after the mid-stream reset.
    @(posedge clk); #1;
    send(-20, 8, 4, -6, TW_ONE, 0, -8, 1, -12, 7, 1'b1);
    drain("drain_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
